fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Write-port arbiter for the asynchronous FIFO write side. Shares the single FIFO write port (write-increment pulse plus write data) among NUM_REQ requesters using round-robin, granting each winner a burst of up to MAX_BURST beats. Sits in the write clock domain directly in front of the FIFO write-pointer logic. Consumes its registered `fifo_full` / `fifo_almost_full` flags, so the FIFO never receives a write while full.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DW`, default 8: data width per requester.
- `MAX_BURST`, default 4: maximum beats per grant, 1..15.

- `clk`, in, 1: write-domain clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, NUM_REQ: requester i has a word on `req_data[i]`.
- `req_data`, in, NUM_REQ*DW: packed data; requester i occupies bits [i*DW +: DW].
- `req_ready`, out, NUM_REQ: requester i's word is accepted this cycle.
- `fifo_full`, in, 1: registered full flag from the FIFO write side.
- `fifo_almost_full`, in, 1: registered flag; exactly one slot is left.
- `wr_inr`, out, 1: write-increment pulse to the FIFO; one word per cycle.
- `wr_data`, out, DW: word written when `wr_inr` is 1.
- `gnt`, out, NUM_REQ: one-hot current grant (registered).
- `busy`, out, 1: FSM is in GRANT.

## Operation
- FSM with two states, IDLE and GRANT. Reset state is IDLE.
- IDLE:
  - If `|req_valid` and `~fifo_full`, select a winner by round-robin. The search starts at `last+1` (mod NUM_REQ), where `last` is the previous winner.
  - Load `gnt` with the winner, clear `beat_cnt`, go to GRANT.
  - Otherwise stay in IDLE with `gnt`=0.
- GRANT, winner g:
  - `req_ready[g] = req_valid[g] & ~fifo_full`. All other `req_ready` bits are 0.
  - `wr_inr = |req_ready`. `wr_data = req_data[g]`.
  - `beat_cnt` increments on each accepted beat. Width is clog2(MAX_BURST)+1.
  - Exit to IDLE on either condition:
    - An accepted beat with `beat_cnt == MAX_BURST-1`.
    - `req_valid[g] == 0` in a cycle. No write occurs in that cycle.
  - On exit: `last <= g`, `gnt <= 0`.
  - While `fifo_full` is 1: stay in GRANT, no write, `beat_cnt` frozen, grant held. There is no timeout.
- `fifo_almost_full` is 1 at GRANT entry: the burst proceeds. The FIFO then raises `fifo_full` after one beat, which stalls the burst.
- A requester must hold `req_data` stable while `req_valid & ~req_ready`.
- A requester that drops `req_valid` loses its burst. It re-arbitrates from IDLE with normal round-robin priority.
- `wr_inr` and `req_ready` are combinational from registered `gnt`, `req_valid` and `fifo_full`. There is no register on the write path.

## Timing
- Reset values: `gnt`=0, `busy`=0, `wr_inr`=0, `req_ready`=0, `wr_data`=0 (mux output with `gnt`=0), `last`=NUM_REQ-1 so requester 0 wins first, `beat_cnt`=0.
- Request to first write: `req_valid` seen in IDLE at cycle t. `gnt` and `busy` are high at t+1. The first `wr_inr` is at t+1 if `fifo_full` is 0.
- Throughput: one word per cycle inside a burst.
- Burst boundary: one mandatory IDLE cycle between bursts. Peak utilisation is MAX_BURST/(MAX_BURST+1).
- Full handling: `fifo_full` reflects all writes up to the previous cycle. Gating `wr_inr` with the current `fifo_full` therefore prevents any overflow.
- `rst` asserted mid-burst: all state clears immediately and `wr_inr` drops in the same cycle (asynchronous). The partially sent burst is not resumed.
- Simultaneous events: full and the last beat in the same cycle means no write and the FSM stays in GRANT. Valid dropping and full in the same cycle means exit to IDLE.

## Test plan
- Reset then single requester: `req_valid`=4'b0001 held, `fifo_full`=0, MAX_BURST=4. Required:
  - `gnt`=0001 one cycle after reset release.
  - `wr_inr` high for 4 consecutive cycles.
  - One IDLE cycle, then another 4-beat burst.
- Round-robin, all four requesting continuously: grant order 0,1,2,3,0. Each grant is 4 beats. `wr_data` matches `req_data[g]` each beat.
- Full stall: `fifo_full` forced high for 3 cycles after beat 2 of requester 1. Required:
  - `wr_inr`=0 and `req_ready`=0 for those 3 cycles.
  - `gnt` stays 0010.
  - Beats 3–4 complete after release, 4 writes total.
- Early release: requester 2 drops valid after 1 beat. Required: FSM returns to IDLE, `last`=2, next winner is 3 if requesting.
- Mid-burst reset: `rst` pulses during beat 2. Required:
  - `wr_inr`, `gnt` and `busy` go to 0 asynchronously.
  - After release, requester 0 wins first.
- Almost-full entry: `fifo_almost_full`=1 at grant and the FIFO model raises `fifo_full` after 1 write. Required: exactly 1 word is written, and there is no write while `fifo_full` is 1.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, bursts of up to MAX_BURST beats.
// Latency: grant one cycle after a request is seen in IDLE; the write path is combinational from the registered grant.
// Backpressure: fifo_full stalls the burst (grant held, no write); one idle cycle separates consecutive bursts.
module fifo_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic                  wr_inr,
  output logic [DW-1:0]         wr_data,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [IW-1:0]      LAST_RST  = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0]      LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] g_idx;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic [BW-1:0] beat_cnt;
  logic          g_valid;
  logic [DW-1:0] g_data;
  logic          accept;

  // Almost-full needs no action here: gating writes with the current full
  // flag already stops the burst once the last slot has been taken.
  logic unused_almost_full;
  assign unused_almost_full = fifo_almost_full;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    win_idx   = last;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req_valid[IW'((int'(last) + k) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(last) + k) % NUM_REQ);
      end
    end
  end

  // Valid and data of the requester currently holding the grant.
  always_comb begin
    g_valid = req_valid[g_idx];
    g_data  = req_data[g_idx*DW +: DW];
  end

  assign busy      = (state == GRANT);
  assign req_ready = (busy && g_valid && !fifo_full) ? gnt : '0;
  assign accept    = |req_ready;
  assign wr_inr    = accept;
  assign wr_data   = busy ? g_data : '0;

  // Grant FSM: pick a winner in IDLE, count accepted beats in GRANT, exit on
  // the last beat or when the winner withdraws its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      g_idx    <= '0;
      last     <= LAST_RST;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid && !fifo_full) begin
            state    <= GRANT;
            gnt      <= ONE << win_idx;
            g_idx    <= win_idx;
            beat_cnt <= '0;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          if (!g_valid || (accept && beat_cnt == LAST_BEAT)) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= g_idx;
          end else if (accept) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios followed by randomized traffic,
// all cycles compared against a transaction-level arbitration model.
module tb_fifo_wr_arb;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_almost_full;
  logic            wr_inr;
  logic [DW-1:0]   wr_data;
  logic [N-1:0]    gnt;
  logic            busy;

  always #5 clk = ~clk;

  fifo_wr_arb #(.NUM_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .wr_inr           (wr_inr),
    .wr_data          (wr_data),
    .gnt              (gnt),
    .busy             (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port, who won last, beats sent so far.
  bit m_busy;
  int m_g;
  int m_last;
  int m_beats;

  // FIFO occupancy environment and observation helpers.
  bit           fifo_en;
  bit           drain_en;
  int           occ;
  int           wr_total;
  logic [N-1:0] rdy_s;
  logic         w_s;
  logic [N-1:0] prev_gnt;
  int           grant_seq[$];
  int           wseq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_g     = 0;
    m_last  = N - 1;
    m_beats = 0;
  endtask

  // One clock cycle: compare outputs at the falling edge, advance the model
  // with the inputs that the coming rising edge will see, then update stimulus.
  task automatic step();
    logic [N-1:0]  e_rdy;
    logic [DW-1:0] e_dat;
    int            d;
    bit            found;
    @(negedge clk);
    e_rdy = '0;
    if (m_busy && req_valid[m_g] && !fifo_full) e_rdy[m_g] = 1'b1;
    e_dat = m_busy ? req_data[m_g*DW +: DW] : '0;
    chk("gnt", 32'(gnt), m_busy ? (32'd1 << m_g) : 32'd0);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("wr_inr", 32'(wr_inr), 32'(|e_rdy));
    chk("wr_data", 32'(wr_data), 32'(e_dat));
    if (fifo_en) chk("no_overflow", 32'(wr_inr && (occ >= DEPTH)), 32'd0);
    rdy_s = req_ready;
    w_s   = wr_inr;
    if (wr_inr) wr_total++;
    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) grant_seq.push_back(i);
    end
    prev_gnt = gnt;

    if (!m_busy) begin
      if (|req_valid && !fifo_full) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req_valid[(m_last + k) % N]) begin
            found = 1'b1;
            m_g   = (m_last + k) % N;
          end
        end
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (!req_valid[m_g]) begin
      m_last = m_g;
      m_busy = 1'b0;
    end else if (!fifo_full) begin
      m_beats++;
      if (m_beats == MB) begin
        m_last = m_g;
        m_busy = 1'b0;
      end
    end

    d = (fifo_en && drain_en && occ > 0 && $urandom_range(0, 2) == 0) ? 1 : 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (rdy_s[i]) req_data[i*DW +: DW] = DW'($urandom);
    if (fifo_en) begin
      occ              = occ + (w_s ? 1 : 0) - d;
      fifo_full        = (occ == DEPTH);
      fifo_almost_full = (occ == DEPTH - 1);
    end
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    req_valid        = '0;
    fifo_full        = 1'b0;
    fifo_almost_full = 1'b0;
    fifo_en          = 1'b0;
    drain_en         = 1'b0;
    occ              = 0;
    prev_gnt         = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    req_valid        = '0;
    req_data         = '0;
    fifo_full        = 1'b0;
    fifo_almost_full = 1'b0;
    fifo_en          = 1'b0;
    drain_en         = 1'b0;
    occ              = 0;
    wr_total         = 0;
    prev_gnt         = '0;
    rdy_s            = '0;
    w_s              = 1'b0;
    model_reset();

    // Reset state, before any clock edge.
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_inr", 32'(wr_inr), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester: two 4-beat bursts separated by one idle cycle.
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    req_valid = 4'b0001;
    wseq.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      wseq.push_back(int'(w_s));
      if (i == 0) chk("first_gnt", 32'(gnt), 32'd1);
    end
    for (int i = 0; i < 10; i++) chk("p1_wr_pattern", 32'(wseq[i]), (i != 0 && i != 5) ? 32'd1 : 32'd0);

    // All four requesting: grant order 0,1,2,3,0 with 4 beats each.
    do_reset();
    req_valid = 4'b1111;
    grant_seq.delete();
    wr_total = 0;
    for (int i = 0; i < 25; i++) step();
    chk("rr_count", 32'(grant_seq.size() >= 5), 32'd1);
    if (grant_seq.size() >= 5) begin
      chk("rr_0", 32'(grant_seq[0]), 32'd0);
      chk("rr_1", 32'(grant_seq[1]), 32'd1);
      chk("rr_2", 32'(grant_seq[2]), 32'd2);
      chk("rr_3", 32'(grant_seq[3]), 32'd3);
      chk("rr_4", 32'(grant_seq[4]), 32'd0);
    end
    chk("rr_writes", 32'(wr_total), 32'd20);

    // Full stall after beat 2 of requester 1.
    do_reset();
    req_valid = 4'b0010;
    wr_total  = 0;
    step();
    step();
    step();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_wr_inr", 32'(wr_inr), 32'd0);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_gnt", 32'(gnt), 32'b0010);
      step();
    end
    fifo_full = 1'b0;
    step();
    step();
    req_valid = '0;
    step();
    chk("stall_writes", 32'(wr_total), 32'd4);
    chk("stall_done_busy", 32'(busy), 32'd0);

    // Early release by requester 2; requester 3 is next ahead of 0.
    do_reset();
    req_valid = 4'b0100;
    step();
    step();
    req_valid = 4'b1001;
    step();
    chk("early_no_write", 32'(w_s), 32'd0);
    chk("early_idle", 32'(busy), 32'd0);
    step();
    chk("early_next_gnt", 32'(gnt), 32'b1000);
    req_valid = '0;
    for (int i = 0; i < 6; i++) step();

    // Reset pulse during beat 2; requester 0 wins afterwards.
    do_reset();
    req_valid = 4'b0010;
    step();
    step();
    @(negedge clk);
    chk("midrst_beat2", 32'(wr_inr), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_wr_inr", 32'(wr_inr), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    model_reset();
    prev_gnt = '0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0011;
    step();
    chk("midrst_first_gnt", 32'(gnt), 32'b0001);
    req_valid = '0;
    for (int i = 0; i < 6; i++) step();

    // Almost full at grant entry: exactly one word until space frees up.
    do_reset();
    fifo_en          = 1'b1;
    occ              = DEPTH - 1;
    fifo_almost_full = 1'b1;
    req_valid        = 4'b0001;
    wr_total         = 0;
    for (int i = 0; i < 8; i++) step();
    chk("af_writes", 32'(wr_total), 32'd1);
    drain_en = 1'b1;
    for (int i = 0; i < 20; i++) step();
    req_valid = '0;
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic with a draining FIFO.
    do_reset();
    fifo_en  = 1'b1;
    drain_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !rdy_s[i]) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'($urandom_range(0, 1));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
